// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchronizer, counter debounce, press/release
// strobes and optional auto-repeat for the board pushbuttons (active-low).

// One key channel: sync -> debounce -> strobes -> repeat FSM.
module key_conditioner_lane #(
  parameter int CW              = 25,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_raw_i,
  output logic key_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  logic          ff1_q, sync_q;
  logic          key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rep_q, rep_d;
  rep_state_e    state_q, state_d;
  logic [CW-1:0] rcnt_q, rcnt_d;

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
  // differing synchronized samples; any agreement restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    key_d   = key_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync_q == key_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      key_d   = sync_q;
      cnt_d   = '0;
      press_d = ~sync_q;
      rel_d   = sync_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Auto-repeat FSM; a release on this edge overrides any terminal count.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rep_d   = 1'b0;
    if (REPEAT_EN == 0) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else if (rel_d) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d = DELAY;
            rcnt_d  = '0;
          end
        end
        DELAY: begin
          if (rcnt_q == RD_LAST) begin
            rep_d   = 1'b1;
            rcnt_d  = '0;
            state_d = REPEAT;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
        REPEAT: begin
          if (rcnt_q == RP_LAST) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // State registers; reset to released level with all counters cleared.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ff1_q   <= 1'b1;
      sync_q  <= 1'b1;
      key_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      ff1_q   <= key_raw_i;
      sync_q  <= ff1_q;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rep_q   <= rep_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign repeat_o  = rep_q;

endmodule

// Top: N_KEYS independent lanes sharing one counter width.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXC   = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAXC) + 1;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_conditioner_lane #(
      .CW              (CW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN)
    ) u_lane (
      .Clk       (Clk),
      .Reset     (Reset),
      .key_raw_i (key_in[g]),
      .key_o     (key_out[g]),
      .press_o   (press_pulse[g]),
      .release_o (release_pulse[g]),
      .repeat_o  (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity,
// all outputs compared every cycle against a window/time-based model.
module tb_key_conditioner;
  localparam int NK = 4, DB = 4, RD = 10, RP = 3;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [NK-1:0] key_in, key_out, press_pulse, release_pulse, repeat_pulse;
  int            checks = 0, failures = 0;

  always #5 Clk = ~Clk;

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_EN(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .key_in(key_in), .key_out(key_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  // Reference model: synchronized-sample history, accepted level, press times.
  logic [NK-1:0] m_ff1, m_sync, m_lvl, e_press, e_rel, e_rep;
  logic [NK-1:0] hist[$];
  int            tnow = 0;
  int            ptime[NK];
  bit            held[NK];

  function automatic void model_reset();
    m_ff1 = '1; m_sync = '1; m_lvl = '1;
    e_press = '0; e_rel = '0; e_rep = '0;
    hist.delete();
    for (int k = 0; k < DB; k++) hist.push_back('1);
    for (int i = 0; i < NK; i++) begin held[i] = 0; ptime[i] = 0; end
  endfunction

  // A level is accepted once the last DB synchronized samples all differ
  // from it; repeats fall at press + RD + n*RP while still held.
  function automatic void model_edge();
    logic [NK-1:0] nlvl, h;
    tnow++;
    if (Reset) begin model_reset(); return; end
    e_press = '0; e_rel = '0; e_rep = '0;
    nlvl = m_lvl;
    for (int i = 0; i < NK; i++) begin
      bit acc = 1;
      for (int k = 1; k <= DB; k++) begin
        h = hist[hist.size() - k];
        if (h[i] == m_lvl[i]) acc = 0;
      end
      if (acc) begin
        nlvl[i] = ~m_lvl[i];
        if (m_lvl[i]) begin e_press[i] = 1'b1; held[i] = 1; ptime[i] = tnow; end
        else begin e_rel[i] = 1'b1; held[i] = 0; end
      end else if (held[i] && (tnow - ptime[i] >= RD) && ((tnow - ptime[i] - RD) % RP == 0)) begin
        e_rep[i] = 1'b1;
      end
    end
    m_lvl  = nlvl;
    m_sync = m_ff1;
    m_ff1  = key_in;
    hist.push_back(m_sync);
    if (hist.size() > 32) void'(hist.pop_front());
  endfunction

  task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_model();
    chk("key_out", key_out, m_lvl);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("repeat_pulse", repeat_pulse, e_rep);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int cd[NK];
    int nrep, rel_at, found;

    Reset = 1'b1; key_in = '1; model_reset();
    repeat (2) tick();
    Reset = 1'b0;
    repeat (3) tick();

    // 1: hold all keys, then reset mid-cycle and re-press after removal
    key_in = 4'h0;
    repeat (8) tick();
    chk("t1_pressed_before_reset", key_out, 4'h0);
    Reset = 1'b1; model_reset(); #1;
    chk("t1_rst_key_out", key_out, 4'hF);
    chk("t1_rst_press", press_pulse, 4'h0);
    chk("t1_rst_release", release_pulse, 4'h0);
    chk("t1_rst_repeat", repeat_pulse, 4'h0);
    repeat (2) tick();
    Reset = 1'b0;
    repeat (5) tick();
    chk("t1_edge5_key_out", key_out, 4'hF);
    tick();
    chk("t1_edge6_key_out", key_out, 4'h0);
    chk("t1_edge6_press", press_pulse, 4'hF);
    tick();
    chk("t1_edge7_press", press_pulse, 4'h0);

    // 2: clean press on key 0
    key_in = 4'hF;
    repeat (8) tick();
    key_in = 4'hE;
    repeat (5) tick();
    chk("t2_edge5_key_out", key_out, 4'hF);
    tick();
    chk("t2_edge6_key_out", key_out, 4'hE);
    chk("t2_edge6_press", press_pulse, 4'h1);
    tick();
    chk("t2_edge7_press", press_pulse, 4'h0);

    // 3: bounce on key 1, then steady low
    found = 0;
    begin
      logic [4:0] pat;
      pat = 5'b10010;  // applied LSB first: 0,1,0,0,1
      for (int p = 0; p < 5; p++) begin
        key_in[1] = pat[p];
        tick();
        if (press_pulse[1]) found++;
      end
    end
    chk("t3_no_accept_in_bounce", {3'b0, key_out[1]}, 4'h1);
    key_in[1] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (press_pulse[1]) begin
        found++;
        chk("t3_press_edge", n[3:0], 4'd6);
      end
    end
    chk("t3_press_count", found[3:0], 4'd1);

    // 4: hold key 2 through repeats, release on a repeat boundary
    key_in[2] = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      tick();
      if (press_pulse[2]) found = 1;
    end
    chk("t4_press_seen", found[3:0], 4'd1);
    nrep = 0;
    for (int n = 1; n <= 31; n++) begin
      tick();
      if (repeat_pulse[2]) nrep++;
      if (n == 10) chk("t4_first_repeat", {3'b0, repeat_pulse[2]}, 4'h1);
    end
    chk("t4_repeat_count", nrep[3:0], 4'd8);
    key_in[2] = 1'b1;
    rel_at = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (release_pulse[2]) begin
        rel_at = n;
        chk("t4_no_repeat_on_release", {3'b0, repeat_pulse[2]}, 4'h0);
      end
    end
    chk("t4_release_edge", rel_at[3:0], 4'd6);

    // 5: keys 0 and 3 together, 3-cycle glitch on key 1
    key_in = 4'hF;
    repeat (8) tick();
    key_in = 4'b0100;
    repeat (3) tick();
    key_in = 4'b0110;
    repeat (3) tick();
    chk("t5_press_pair", press_pulse, 4'b1001);
    repeat (6) tick();
    chk("t5_key_out", key_out, 4'b0110);

    // 6: reset while key 2 is repeating, key still held afterwards
    key_in = 4'hF;
    repeat (8) tick();
    key_in = 4'b1011;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      tick();
      if (press_pulse[2]) found = 1;
    end
    chk("t6_press_seen", found[3:0], 4'd1);
    repeat (12) tick();
    Reset = 1'b1; model_reset(); #1;
    chk("t6_rst_repeat", repeat_pulse, 4'h0);
    chk("t6_rst_key_out", key_out, 4'hF);
    repeat (3) tick();
    Reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 6)  chk("t6_press_after_reset", press_pulse, 4'b0100);
      if (n == 16) chk("t6_first_repeat", repeat_pulse, 4'b0100);
    end

    // 7: random per-key activity with mixed short glitches and long holds
    for (int i = 0; i < NK; i++) cd[i] = $urandom_range(1, 20);
    repeat (500) begin
      for (int i = 0; i < NK; i++) begin
        if (cd[i] == 0) begin
          key_in[i] = ~key_in[i];
          cd[i] = $urandom_range(0, 1) ? $urandom_range(1, 6) : $urandom_range(7, 30);
        end else begin
          cd[i]--;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the raw DE2-115 pushbutton inputs (KEY[3:0], active-low, bouncing, asynchronous) before they reach the SoC key PIO input.
- Per key: 2-FF synchronizer, counter-based debounce, press/release strobes, and optional auto-repeat strobe for held keys.
- Sits between the board pins and the key PIO input of the NIOS SoC. The debounced level bus drives the PIO directly; the strobes are available to hardware FSMs.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive synchronized-stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2..2^24-1.
- REPEAT_DELAY, 25000000, cycles a key must be held after press before the first repeat strobe (0.5 s).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes (0.1 s).
- REPEAT_EN, 1, 1 enables auto-repeat; 0 forces repeat_pulse to 0.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high reset.
- key_in  in  N_KEYS  raw pin level, active-low (0 = pressed), asynchronous to Clk.
- key_out  out  N_KEYS  debounced level, same polarity as key_in; feeds the SoC key PIO.
- press_pulse  out  N_KEYS  one-cycle strobe when key_out[i] goes 1->0.
- release_pulse  out  N_KEYS  one-cycle strobe when key_out[i] goes 0->1.
- repeat_pulse  out  N_KEYS  one-cycle strobe per auto-repeat interval while held.

Behaviour:
- Reset (async assert, removal synchronous to Clk):
  - Sync FFs, key_out: all 1 (released).
  - Debounce and repeat counters: 0.
  - All pulse outputs: 0.
- Channels are fully independent. Every output is registered, with no combinational path from key_in.
- Synchronizer: ff1 <= key_in, then sync <= ff1.
- Debounce, per channel, each edge:
  - If sync == key_out, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: key_out <= sync and cnt <= 0. On the same edge, press_pulse (new level 0) or release_pulse (new level 1) goes high for exactly one cycle.
  - Else cnt <= cnt+1.
- Latency: if key_in settles to a new value and the first edge samples it as edge 1, key_out and the strobe change on edge DEBOUNCE_CYCLES+2.
- A bounce back to the old level before acceptance clears cnt; acceptance then restarts from 0. A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never reaches key_out.
- Counter width: ceil(log2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)))+1. Counters never wrap.
- Auto-repeat, per channel, FSM states IDLE / DELAY / REPEAT:
  - IDLE -> DELAY on the press_pulse edge; rcnt <= 0.
  - DELAY: rcnt increments. When rcnt == REPEAT_DELAY-1: one-cycle repeat_pulse, rcnt <= 0, go to REPEAT.
  - REPEAT: rcnt increments. When rcnt == REPEAT_PERIOD-1: one-cycle repeat_pulse, rcnt <= 0.
  - Any state -> IDLE on the edge key_out becomes 1. The release edge does not also emit repeat_pulse, even if rcnt hits its terminal value that cycle. Release wins.
  - REPEAT_EN = 0: FSM held in IDLE.
- press_pulse never coincides with repeat_pulse. The first repeat strobe comes REPEAT_DELAY edges after press_pulse.
- Reset mid-debounce or mid-repeat: all state returns to reset values immediately. After removal, a key still held is treated as a fresh press, so press_pulse follows DEBOUNCE_CYCLES+2 edges later.
- Multiple keys changing on the same edge each produce their own strobes on the same cycle.

Test Plan:
- All tests use N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset: assert Reset mid-cycle with key_in=4'b0000 -> key_out=4'hF and all pulses 0 immediately. Release Reset -> key_out=4'hE..0 behaviour: key_out=4'h0 on edge 6, press_pulse=4'hF for 1 cycle.
2. Clean press on key 0 (key_in 4'hF->4'hE, sampled edge 1) -> key_out=4'hE on edge 6; press_pulse=4'h1 for exactly one cycle on edge 6.
3. Bounce on key 1: pattern 0,1,0,0,1 per cycle, then steady 0 -> key_out[1] stays 1 through the bounce; changes 6 edges after the last 1->0, with a single press_pulse.
4. Hold key 2 for 30 cycles after acceptance, then release:
   - repeat_pulse[2] at 10, 13, 16, 19, 22, 25, 28 cycles after press_pulse.
   - No repeat on the release edge.
   - release_pulse[2] 6 edges after key_in returns to 1.
5. Keys 0 and 3 pressed on the same edge -> press_pulse=4'b1001 on one cycle; key 1 glitch of 3 cycles at the same time -> no effect on key_out[1].
6. Assert Reset while key 2 is in REPEAT -> repeat_pulse stops at once. After removal with key still held -> press_pulse at edge 6, first repeat 10 cycles later.
